// File: rtl/clause_sweep_controller.sv
// Clause-memory sweep sequencer: issues every row to the evaluator, collects satisfied masks in order,
// and reports completion, first conflict (row / global clause index) and a running satisfied-clause count.
module clause_sweep_controller #(
  parameter int NUM_CLAUSES           = 64,
  parameter int NUM_CLAUSES_PER_CYCLE = 16,
  parameter bit EARLY_EXIT            = 1'b0,
  localparam int NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
  localparam int RB       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CB       = $clog2(NUM_CLAUSES),
  localparam int SB       = $clog2(NUM_CLAUSES + 1)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic                             i_abort,
  output logic [RB-1:0]                    o_row_addr,
  output logic                             o_row_valid,
  input  logic                             i_row_ready,
  input  logic                             i_eval_valid,
  input  logic [NUM_CLAUSES_PER_CYCLE-1:0] i_eval_sat_mask,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_all_sat,
  output logic                             o_conflict,
  output logic [RB-1:0]                    o_conflict_row,
  output logic [CB-1:0]                    o_conflict_clause,
  output logic [SB-1:0]                    o_sat_count
);

  localparam int NP = NUM_CLAUSES_PER_CYCLE;
  localparam int IB = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW = RB + 1;
  localparam logic [CW-1:0] ROWS_CNT = CW'(NUM_ROWS);
  localparam logic [RB-1:0] LAST_ROW = RB'(NUM_ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_issued_cnt;
  logic [CW-1:0] r_res_cnt;
  logic [RB-1:0] r_row_addr;
  logic          r_conflict;
  logic [RB-1:0] r_conflict_row;
  logic [CB-1:0] r_conflict_clause;
  logic [SB-1:0] r_sat_count;

  logic          w_active;
  logic          w_issue_done;
  logic          w_row_valid;
  logic          w_hs;
  logic [CW-1:0] w_issued_nxt;
  logic          w_acc;
  logic [CW-1:0] w_res_nxt;
  logic          w_new_conf;
  logic          w_conflict_nxt;
  logic          w_finish_nxt;
  logic          w_clear;
  logic [CB-1:0] w_clause;

  function automatic logic [SB-1:0] popcount(input logic [NP-1:0] m);
    logic [SB-1:0] c;
    c = '0;
    for (int i = 0; i < NP; i++) c = c + SB'(m[i]);
    return c;
  endfunction

  function automatic logic [IB-1:0] lowest_zero(input logic [NP-1:0] m);
    logic [IB-1:0] idx;
    idx = '0;
    for (int i = NP - 1; i >= 0; i--) if (!m[i]) idx = IB'(i);
    return idx;
  endfunction

  assign w_active     = (r_state == S_SWEEP) || (r_state == S_DRAIN);
  assign w_issue_done = (r_issued_cnt == ROWS_CNT) || (EARLY_EXIT && r_conflict);
  assign w_row_valid  = (r_state == S_SWEEP) && !w_issue_done;
  assign w_hs         = w_row_valid && i_row_ready;
  assign w_issued_nxt = r_issued_cnt + CW'(w_hs);

  // A result may belong to the row handed over in this very cycle (zero-latency evaluator).
  assign w_acc          = w_active && i_eval_valid && (r_res_cnt < w_issued_nxt);
  assign w_res_nxt      = r_res_cnt + CW'(w_acc);
  assign w_new_conf     = w_acc && !r_conflict && (i_eval_sat_mask != '1);
  assign w_conflict_nxt = r_conflict || w_new_conf;
  assign w_finish_nxt   = (w_issued_nxt == ROWS_CNT) || (EARLY_EXIT && w_conflict_nxt);
  assign w_clause       = CB'(r_res_cnt[RB-1:0]) * CB'(NP) + CB'(lowest_zero(i_eval_sat_mask));

  assign w_clear = (((r_state == S_IDLE) || (r_state == S_DONE)) && i_start) ||
                   (w_active && i_abort);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SWEEP;
      S_SWEEP: begin
        if (i_abort)           w_state_nxt = S_IDLE;
        else if (w_finish_nxt) w_state_nxt = (w_res_nxt == w_issued_nxt) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (i_abort)                       w_state_nxt = S_IDLE;
        else if (w_res_nxt == w_issued_nxt) w_state_nxt = S_DONE;
      end
      S_DONE:  if (i_start) w_state_nxt = S_SWEEP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_issued_cnt      <= '0;
      r_res_cnt         <= '0;
      r_row_addr        <= '0;
      r_conflict        <= 1'b0;
      r_conflict_row    <= '0;
      r_conflict_clause <= '0;
      r_sat_count       <= '0;
    end else if (w_clear) begin
      r_issued_cnt      <= '0;
      r_res_cnt         <= '0;
      r_row_addr        <= '0;
      r_conflict        <= 1'b0;
      r_conflict_row    <= '0;
      r_conflict_clause <= '0;
      r_sat_count       <= '0;
    end else if (w_active) begin
      if (w_hs) begin
        r_issued_cnt <= w_issued_nxt;
        r_row_addr   <= (r_row_addr == LAST_ROW) ? '0 : r_row_addr + RB'(1);
      end
      if (w_acc) begin
        r_res_cnt   <= w_res_nxt;
        r_sat_count <= r_sat_count + popcount(i_eval_sat_mask);
      end
      if (w_new_conf) begin
        r_conflict        <= 1'b1;
        r_conflict_row    <= r_res_cnt[RB-1:0];
        r_conflict_clause <= w_clause;
      end
    end
  end

  assign o_row_addr        = r_row_addr;
  assign o_row_valid       = w_row_valid;
  assign o_busy            = w_active;
  assign o_done            = (r_state == S_DONE);
  assign o_all_sat         = (r_state == S_DONE) && !r_conflict;
  assign o_conflict        = r_conflict;
  assign o_conflict_row    = r_conflict_row;
  assign o_conflict_clause = r_conflict_clause;
  assign o_sat_count       = r_sat_count;

endmodule

// File: tb/tb_clause_sweep_controller.sv
// Directed bench for clause_sweep_controller: one instance per EARLY_EXIT setting sharing a behavioural
// evaluator with programmable latency; issued rows are checked against a scoreboard of expected (row, cycle).
module tb_clause_sweep_controller;
  localparam int NP = 16;
  localparam int RB = 2;
  localparam int CB = 6;
  localparam int SB = 7;

  typedef struct {
    int addr;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic row_ready = 1'b1;
  logic stray = 1'b0;
  logic sel = 1'b0;
  int   lat = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [NP-1:0] tbl [4];
  exp_t          sb_q [$];
  int            due_q [$];
  logic [NP-1:0] msk_q [$];
  logic          ev_r = 1'b0;
  logic [NP-1:0] msk_r = '0;

  logic [RB-1:0] w_ra [2];
  logic          w_rv [2];
  logic          w_busy [2];
  logic          w_done [2];
  logic          w_asat [2];
  logic          w_conf [2];
  logic [RB-1:0] w_crow [2];
  logic [CB-1:0] w_ccl [2];
  logic [SB-1:0] w_sat [2];

  logic          start0, start1, abort0, abort1, hs, ev;
  logic [NP-1:0] msk;
  logic [RB-1:0] row_addr;
  logic          row_valid, busy, done, all_sat, conflict;
  logic [RB-1:0] conflict_row;
  logic [CB-1:0] conflict_clause;
  logic [SB-1:0] sat_count;

  always #5 clk = ~clk;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign abort0 = abort & ~sel;
  assign abort1 = abort & sel;

  assign row_addr        = sel ? w_ra[1]   : w_ra[0];
  assign row_valid       = sel ? w_rv[1]   : w_rv[0];
  assign busy            = sel ? w_busy[1] : w_busy[0];
  assign done            = sel ? w_done[1] : w_done[0];
  assign all_sat         = sel ? w_asat[1] : w_asat[0];
  assign conflict        = sel ? w_conf[1] : w_conf[0];
  assign conflict_row    = sel ? w_crow[1] : w_crow[0];
  assign conflict_clause = sel ? w_ccl[1]  : w_ccl[0];
  assign sat_count       = sel ? w_sat[1]  : w_sat[0];

  assign hs  = row_valid && row_ready;
  assign ev  = stray | ((lat == 0) ? hs : ev_r);
  assign msk = stray ? '1 : ((lat == 0) ? tbl[row_addr] : msk_r);

  clause_sweep_controller #(.NUM_CLAUSES(64), .NUM_CLAUSES_PER_CYCLE(16), .EARLY_EXIT(1'b0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0),
    .o_row_addr(w_ra[0]), .o_row_valid(w_rv[0]), .i_row_ready(row_ready),
    .i_eval_valid(ev), .i_eval_sat_mask(msk),
    .o_busy(w_busy[0]), .o_done(w_done[0]), .o_all_sat(w_asat[0]), .o_conflict(w_conf[0]),
    .o_conflict_row(w_crow[0]), .o_conflict_clause(w_ccl[0]), .o_sat_count(w_sat[0])
  );

  clause_sweep_controller #(.NUM_CLAUSES(64), .NUM_CLAUSES_PER_CYCLE(16), .EARLY_EXIT(1'b1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1),
    .o_row_addr(w_ra[1]), .o_row_valid(w_rv[1]), .i_row_ready(row_ready),
    .i_eval_valid(ev), .i_eval_sat_mask(msk),
    .o_busy(w_busy[1]), .o_done(w_done[1]), .o_all_sat(w_asat[1]), .o_conflict(w_conf[1]),
    .o_conflict_row(w_crow[1]), .o_conflict_clause(w_ccl[1]), .o_sat_count(w_sat[1])
  );

  // Evaluator model: each accepted row returns its table mask lat cycles later, in order.
  always @(posedge clk) begin
    if (rst) begin
      due_q.delete();
      msk_q.delete();
    end else begin
      if (lat > 0 && ev_r && due_q.size() > 0) begin
        void'(due_q.pop_front());
        void'(msk_q.pop_front());
      end
      if (lat > 0 && hs) begin
        due_q.push_back(cyc + lat);
        msk_q.push_back(tbl[row_addr]);
      end
    end
    cyc++;
    if (!rst && due_q.size() > 0 && due_q[0] == cyc) begin
      ev_r  <= 1'b1;
      msk_r <= msk_q[0];
    end else begin
      ev_r  <= 1'b0;
      msk_r <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !abort && hs) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_row_handshake", 32'(row_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("issued_row_addr", 32'(row_addr), 32'(e.addr));
        chk("issued_row_cycle", 32'(cyc - t0), 32'(e.cyc - t0));
      end
    end
  end

  task automatic goto(input int k);
    while (cyc < t0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_at(input int k);
    goto(k);
    @(negedge clk);
  endtask

  task automatic kick();
    @(posedge clk);
    #1;
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic go();
    goto(1);
    start = 1'b0;
  endtask

  task automatic sb(input int a, input int c);
    exp_t e;
    e.addr = a;
    e.cyc  = t0 + c;
    sb_q.push_back(e);
  endtask

  task automatic fill(input logic [NP-1:0] m);
    for (int i = 0; i < 4; i++) tbl[i] = m;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    fill('1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row_addr", 32'(row_addr), 0);
    chk("rst_row_valid", 32'(row_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_all_sat", 32'(all_sat), 0);
    chk("rst_conflict", 32'(conflict), 0);
    chk("rst_conflict_clause", 32'(conflict_clause), 0);
    chk("rst_sat_count", 32'(sat_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Clean sweep, zero latency
    kick();
    for (int r = 0; r < 4; r++) sb(r, 1 + r);
    go();
    @(negedge clk);
    chk("t1_busy_c1", 32'(busy), 1);
    chk("t1_row_valid_c1", 32'(row_valid), 1);
    chk("t1_row_addr_c1", 32'(row_addr), 0);
    chk_at(4);
    chk("t1_done_c4", 32'(done), 0);
    chk_at(5);
    chk("t1_done_c5", 32'(done), 1);
    chk("t1_all_sat", 32'(all_sat), 1);
    chk("t1_sat_count", 32'(sat_count), 64);
    chk("t1_conflict", 32'(conflict), 0);
    chk("t1_busy_c5", 32'(busy), 0);
    chk("t1_sb_empty", 32'(sb_q.size()), 0);

    // Backpressure in cycles 2-3
    kick();
    sb(0, 1); sb(1, 4); sb(2, 5); sb(3, 6);
    go();
    goto(2);
    row_ready = 1'b0;
    chk_at(3);
    chk("t2_row_addr_hold", 32'(row_addr), 1);
    chk("t2_row_valid_hold", 32'(row_valid), 1);
    goto(4);
    row_ready = 1'b1;
    chk_at(6);
    chk("t2_done_c6", 32'(done), 0);
    chk_at(7);
    chk("t2_done_c7", 32'(done), 1);
    chk("t2_sat_count", 32'(sat_count), 64);
    chk("t2_sb_empty", 32'(sb_q.size()), 0);

    // Conflicts on rows 2 and 3, no early exit
    tbl[2] = 16'hFFEF;
    tbl[3] = 16'h7FFF;
    kick();
    for (int r = 0; r < 4; r++) sb(r, 1 + r);
    go();
    chk_at(4);
    chk("t3_conflict_c4", 32'(conflict), 1);
    chk("t3_clause_c4", 32'(conflict_clause), 36);
    chk_at(5);
    chk("t3_done", 32'(done), 1);
    chk("t3_all_sat", 32'(all_sat), 0);
    chk("t3_conflict_row", 32'(conflict_row), 2);
    chk("t3_conflict_clause", 32'(conflict_clause), 36);
    chk("t3_sat_count", 32'(sat_count), 62);
    chk("t3_sb_empty", 32'(sb_q.size()), 0);

    // Early exit instance, latency 2, conflict on row 0
    sel = 1'b1;
    lat = 2;
    fill('1);
    tbl[0] = 16'hFFFE;
    kick();
    sb(0, 1); sb(1, 2); sb(2, 3);
    go();
    chk_at(3);
    chk("t4_row_valid_c3", 32'(row_valid), 1);
    chk("t4_conflict_c3", 32'(conflict), 0);
    chk_at(4);
    chk("t4_row_valid_c4", 32'(row_valid), 0);
    chk("t4_busy_c4", 32'(busy), 1);
    chk("t4_conflict_c4", 32'(conflict), 1);
    chk_at(5);
    chk("t4_done_c5", 32'(done), 0);
    chk_at(6);
    chk("t4_done_c6", 32'(done), 1);
    chk("t4_conflict_row", 32'(conflict_row), 0);
    chk("t4_conflict_clause", 32'(conflict_clause), 0);
    chk("t4_sat_count", 32'(sat_count), 47);
    chk("t4_all_sat", 32'(all_sat), 0);
    chk("t4_sb_empty", 32'(sb_q.size()), 0);

    // Restart from DONE (clears prior conflict), then abort at cycle 2
    sel = 1'b0;
    lat = 0;
    fill('1);
    kick();
    sb(0, 1);
    go();
    @(negedge clk);
    chk("t5_conflict_cleared", 32'(conflict), 0);
    chk("t5_sat_cleared", 32'(sat_count), 0);
    chk("t5_busy_c1", 32'(busy), 1);
    goto(2);
    abort = 1'b1;
    goto(3);
    abort = 1'b0;
    @(negedge clk);
    chk("t5_busy_after_abort", 32'(busy), 0);
    chk("t5_sat_after_abort", 32'(sat_count), 0);
    chk("t5_row_addr_after_abort", 32'(row_addr), 0);
    chk("t5_row_valid_after_abort", 32'(row_valid), 0);
    chk("t5_conflict_after_abort", 32'(conflict), 0);
    for (int k = 3; k < 9; k++) begin
      chk_at(k);
      chk("t5_no_done", 32'(done), 0);
    end
    goto(9);
    stray = 1'b1;
    goto(10);
    stray = 1'b0;
    @(negedge clk);
    chk("t5_stray_ignored", 32'(sat_count), 0);
    chk("t5_sb_empty", 32'(sb_q.size()), 0);

    // Async reset while draining (latency 3)
    lat = 3;
    kick();
    for (int r = 0; r < 4; r++) sb(r, 1 + r);
    go();
    chk_at(5);
    chk("t6_busy_drain", 32'(busy), 1);
    chk("t6_row_valid_drain", 32'(row_valid), 0);
    chk("t6_sat_drain", 32'(sat_count), 16);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_sat", 32'(sat_count), 0);
    chk("t6_rst_row_addr", 32'(row_addr), 0);
    chk("t6_rst_conflict", 32'(conflict), 0);
    chk("t6_sb_empty", 32'(sb_q.size()), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    lat = 0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_sweep_controller.md
# clause_sweep_controller

Sequencer for the static clause memory in the SAT datapath. On `start` it walks the memory row pointer through every row (NUM_CLAUSES_PER_CYCLE clauses per row) and hands each slice to the clause evaluator with a valid/ready handshake. It collects the evaluator's per-clause satisfied masks, in order, and reports sweep completion, all-satisfied or first conflict (row and clause index), and a satisfied-clause count. It sits between the solver top-level FSM and the static_memory/evaluator pair.

## Interface
- NUM_CLAUSES, 64, total clauses; must be a multiple of NUM_CLAUSES_PER_CYCLE.
- NUM_CLAUSES_PER_CYCLE, 16, clauses per memory row.
- EARLY_EXIT, 0, 1 = stop issuing rows after the first conflict.
- Derived: NUM_ROWS = NUM_CLAUSES/NUM_CLAUSES_PER_CYCLE; RB = max(1, clog2(NUM_ROWS)); CB = clog2(NUM_CLAUSES); SB = clog2(NUM_CLAUSES+1).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured in IDLE and DONE only.
- abort  in  1  cancel the sweep; honoured in SWEEP and DRAIN.
- row_addr  out  RB  row pointer to static_memory; the memory read is combinational.
- row_valid  out  1  memory slice at row_addr is offered to the evaluator.
- row_ready  in  1  evaluator accepts the slice.
- eval_valid  in  1  evaluator result strobe; results arrive in issue order with any latency ≥0.
- eval_sat_mask  in  NUM_CLAUSES_PER_CYCLE  bit i = clause i of that row satisfied.
- busy  out  1  high in SWEEP or DRAIN.
- done  out  1  high while in DONE.
- all_sat  out  1  done && !conflict.
- conflict  out  1  an unsatisfied clause has been seen this sweep (sticky until next start/abort).
- conflict_row  out  RB  row of the first conflict.
- conflict_clause  out  CB  global index of the first conflict: row*NUM_CLAUSES_PER_CYCLE + lowest zero bit.
- sat_count  out  SB  running popcount of received masks.

## Operation
- State IDLE:
  - start → SWEEP.
  - On entry to SWEEP: clear the counters, conflict, conflict_row, conflict_clause and sat_count; set row_addr = 0.
- State SWEEP:
  - row_valid = 1 unless EARLY_EXIT && conflict.
  - A handshake (row_valid && row_ready) increments issued_cnt (RB+1 bits) and row_addr.
  - After the handshake of row NUM_ROWS-1, row_addr wraps to 0 and row_valid drops.
- Result acceptance:
  - eval_valid with res_cnt < issued_cnt (counting a same-cycle handshake) is accepted.
  - Acceptance adds popcount(mask) to sat_count.
  - If the mask is not all ones and conflict = 0, record conflict_row = res_cnt and conflict_clause, then set conflict.
  - Acceptance increments res_cnt.
  - eval_valid with no outstanding row, or in IDLE/DONE, is ignored.
- Transitions, evaluated on post-update counts:
  - SWEEP → DRAIN when issuing is finished (issued_cnt == NUM_ROWS, or EARLY_EXIT && conflict) and res_cnt < issued_cnt.
  - SWEEP → DONE directly if issuing is finished and res_cnt == issued_cnt.
  - DRAIN → DONE when res_cnt == issued_cnt.
- State DONE:
  - Outputs hold.
  - start → SWEEP with the clears above.
- abort in SWEEP or DRAIN:
  - → IDLE next cycle.
  - Clears all status outputs and row_addr.
  - No done is produced.
  - abort outranks any same-cycle handshake or result.
- start in SWEEP/DRAIN and abort in IDLE/DONE are ignored.
- rst mid-sweep: immediate return to IDLE with reset values.

## Timing
- Reset values: row_addr 0, row_valid 0, busy 0, done 0, all_sat 0, conflict 0, conflict_row 0, conflict_clause 0, sat_count 0; state IDLE.
- start at cycle 0:
  - busy = 1 and row_valid = 1 with row_addr = 0 from cycle 1.
  - With row_ready held high, row r is accepted in cycle 1+r.
- Evaluator latency L: the result for row r arrives at cycle 1+r+L.
- done rises at cycle NUM_ROWS+L+1; for NUM_ROWS=4 and L=0 that is cycle 5.
- Status outputs are registered. conflict, conflict_row, conflict_clause and sat_count update the cycle after the accepting edge.
- EARLY_EXIT:
  - A conflict accepted at cycle t drops row_valid from cycle t+1.
  - A handshake in cycle t itself still counts as issued and must be drained.
- row_ready low holds row_addr and row_valid unchanged (no drop, no skip).

## Test plan
Defaults apply throughout: NUM_ROWS = 4.

1. **Clean sweep:** all masks 0xFFFF, L=0, row_ready=1, start at cycle 0 → row_addr 0,1,2,3 in cycles 1-4; done=1 and all_sat=1 at cycle 5; sat_count=64, conflict=0.
2. **Backpressure:** row_ready low in cycles 2-3 → row_addr holds 1 through cycle 3; rows accepted at cycles 1,4,5,6; done at cycle 7.
3. **Conflict, EARLY_EXIT=0:**
   - Stimulus: row 2 mask 0xFFEF, row 3 mask 0x7FFF.
   - Required: conflict=1, conflict_row=2, conflict_clause=36, all_sat=0, sat_count=62; all 4 rows issued.
4. **Conflict, EARLY_EXIT=1, L=2:**
   - Stimulus: row 0 mask 0xFFFE.
   - Required: row_valid drops after the row-0 result arrives (cycle 3).
   - Required: rows 0-2 issued, then DRAIN until 3 results are received; done at cycle 6.
   - Required: conflict_clause=0, sat_count=47.
5. **Abort / restart:**
   - abort at cycle 2 → IDLE at cycle 3, all status 0, done never asserts.
   - A stray eval_valid in IDLE is ignored (sat_count stays 0).
   - start from DONE clears the prior conflict and re-sweeps.
6. **Async reset:** rst asserted mid-DRAIN → outputs reach reset values without a clock edge.
